// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states and the
// instruction-class codes produced by the opcode decoder.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ALU3_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU3_LAST  = 5'b01100;
    localparam logic [4:0] OP_ALUI_FIRST = 5'b01101;
    localparam logic [4:0] OP_ALUI_LAST  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_NEG  = 5'b10010;
    localparam logic [4:0] OP_NOT  = 5'b10011;
    localparam logic [4:0] OP_BR   = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_JAL  = 5'b10110;
    localparam logic [4:0] OP_IN   = 5'b10111;
    localparam logic [4:0] OP_OUT  = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_MFLO = 5'b11010;
    localparam logic [4:0] OP_NOP  = 5'b11011;
    localparam logic [4:0] OP_HALT = 5'b11100;

    typedef enum logic [3:0] {
        RST, F0, F1, F2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU3, CLS_ALUI, CLS_MULDIV, CLS_NEGNOT,
        CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO,
        CLS_NOP, CLS_HALT
    } cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// Maps a 5-bit opcode onto the instruction class the sequencer steps through.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls
);

    always_comb begin
        cls = CLS_NOP;
        if (opcode >= OP_ALU3_FIRST && opcode <= OP_ALU3_LAST) begin
            cls = CLS_ALU3;
        end else if (opcode >= OP_ALUI_FIRST && opcode <= OP_ALUI_LAST) begin
            cls = CLS_ALUI;
        end else begin
            // Anything not listed (including 11101-11111) stays a nop
            case (opcode)
                OP_LD:   cls = CLS_LD;
                OP_LDI:  cls = CLS_LDI;
                OP_ST:   cls = CLS_ST;
                OP_MUL,
                OP_DIV:  cls = CLS_MULDIV;
                OP_NEG,
                OP_NOT:  cls = CLS_NEGNOT;
                OP_BR:   cls = CLS_BR;
                OP_JR:   cls = CLS_JR;
                OP_JAL:  cls = CLS_JAL;
                OP_IN:   cls = CLS_IN;
                OP_OUT:  cls = CLS_OUT;
                OP_MFHI: cls = CLS_MFHI;
                OP_MFLO: cls = CLS_MFLO;
                OP_HALT: cls = CLS_HALT;
                default: cls = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the datapath: fetch F0-F2, then per-class execute steps
// T3-T7. Class is decoded from IR in T3 and held for the remaining steps.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_in,
    input  logic        CON_ff,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        PC_enable,
    output logic        Z_enable,
    output logic        MDR_enable,
    output logic        MAR_enable,
    output logic        Y_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        IR_enable,
    output logic        OutPort_enable,
    output logic        PCout,
    output logic        ZHighout,
    output logic        ZLowout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        CONin,
    output logic        run
);

    state_t state_reg, state_next;
    cls_t   cls_reg, dec_cls, cur_cls;
    logic   br_taken_reg;
    logic   unused_ir;

    assign unused_ir = ^IR_in[26:0];

    ctrl_decode u_decode (
        .opcode (IR_in[31:27]),
        .cls    (dec_cls)
    );

    // T3 acts on the freshly loaded IR; later steps use the latched class
    assign cur_cls = (state_reg == T3) ? dec_cls : cls_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg    <= RST;
            cls_reg      <= CLS_NOP;
            br_taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == T3) begin
                cls_reg <= dec_cls;
                if (dec_cls == CLS_BR) begin
                    br_taken_reg <= CON_ff;
                end
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        Read           = 1'b0;
        Write          = 1'b0;
        IncPC          = 1'b0;
        PC_enable      = 1'b0;
        Z_enable       = 1'b0;
        MDR_enable     = 1'b0;
        MAR_enable     = 1'b0;
        Y_enable       = 1'b0;
        HI_enable      = 1'b0;
        LO_enable      = 1'b0;
        IR_enable      = 1'b0;
        OutPort_enable = 1'b0;
        PCout          = 1'b0;
        ZHighout       = 1'b0;
        ZLowout        = 1'b0;
        HIout          = 1'b0;
        LOout          = 1'b0;
        MDRout         = 1'b0;
        InPortout      = 1'b0;
        Cout           = 1'b0;
        BAout          = 1'b0;
        Gra            = 1'b0;
        Grb            = 1'b0;
        Grc            = 1'b0;
        Rin            = 1'b0;
        Rout           = 1'b0;
        CONin          = 1'b0;
        run            = 1'b1;

        case (state_reg)
            RST: state_next = F0;
            F0: begin
                PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1;
                state_next = F1;
            end
            F1: begin
                Read = 1'b1; MDR_enable = 1'b1;
                state_next = F2;
            end
            F2: begin
                MDRout = 1'b1; IR_enable = 1'b1;
                state_next = T3;
            end
            T3: begin
                state_next = F0;
                case (cur_cls)
                    CLS_ALU3, CLS_ALUI: begin
                        Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1; state_next = T4;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                        state_next = T4;
                    end
                    CLS_MULDIV: begin
                        Gra = 1'b1; Rout = 1'b1; Y_enable = 1'b1; state_next = T4;
                    end
                    CLS_NEGNOT: begin
                        Grb = 1'b1; Rout = 1'b1; Z_enable = 1'b1; state_next = T4;
                    end
                    CLS_BR: begin
                        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_next = T4;
                    end
                    CLS_JAL: begin
                        PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; state_next = T4;
                    end
                    CLS_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
                    CLS_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1; end
                    CLS_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_HALT: state_next = HALT;
                    default:  state_next = F0;
                endcase
            end
            T4: begin
                state_next = T5;
                case (cur_cls)
                    CLS_ALU3: begin Grc = 1'b1; Rout = 1'b1; Z_enable = 1'b1; end
                    CLS_ALUI, CLS_LD, CLS_LDI, CLS_ST: begin
                        Cout = 1'b1; Z_enable = 1'b1;
                    end
                    CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Z_enable = 1'b1; end
                    CLS_BR: begin PCout = 1'b1; Y_enable = 1'b1; end
                    CLS_NEGNOT: begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = F0;
                    end
                    CLS_JAL: begin
                        Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; state_next = F0;
                    end
                    default: state_next = F0;
                endcase
            end
            T5: begin
                state_next = T6;
                case (cur_cls)
                    CLS_ALU3, CLS_ALUI, CLS_LDI: begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = F0;
                    end
                    CLS_LD, CLS_ST: begin ZLowout = 1'b1; MAR_enable = 1'b1; end
                    CLS_MULDIV:     begin ZLowout = 1'b1; LO_enable = 1'b1; end
                    CLS_BR:         begin Cout = 1'b1; Z_enable = 1'b1; end
                    default: state_next = F0;
                endcase
            end
            T6: begin
                state_next = F0;
                case (cur_cls)
                    CLS_LD: begin Read = 1'b1; MDR_enable = 1'b1; state_next = T7; end
                    CLS_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; state_next = T7;
                    end
                    CLS_MULDIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
                    CLS_BR: begin
                        ZLowout = br_taken_reg; PC_enable = br_taken_reg;
                    end
                    default: state_next = F0;
                endcase
            end
            T7: begin
                state_next = F0;
                if (cur_cls == CLS_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (cur_cls == CLS_ST) begin
                    Write = 1'b1;
                end
            end
            HALT: run = 1'b0;
            default: state_next = RST;
        endcase
    end

endmodule
